// File: rtl/range_sequencer.sv
// range_sequencer: buffers whole valid/ready sample sequences in a FIFO and replays
// each one as a gap-free go/data/finish burst for the range finder.
module range_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] seq_data,
  output logic             seq_go,
  output logic             seq_finish,
  output logic             busy,
  output logic             len_error
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, REPEAT} state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    pend;
  logic             discard;
  logic             full, accept, push, pop, launch, overflow;
  logic [EW-1:0]    head;
  logic             head_last;
  logic [WIDTH-1:0] head_data;
  logic             go_nxt, finish_nxt;
  logic [WIDTH-1:0] data_nxt;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = ~full | discard;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~discard;
  // A full FIFO with no complete sequence inside can never drain
  assign overflow  = full & (pend == '0) & ~discard;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_last = head[WIDTH];
  assign head_data = head[WIDTH-1:0];
  assign busy      = (state != IDLE);

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  // FIFO pointers; overflow flushes by collapsing the write pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (overflow)  wr_ptr <= rd_ptr;
      else if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Complete sequences waiting in the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if ((push & in_last) != launch) begin
      pend <= launch ? pend - CW'(1) : pend + CW'(1);
    end
  end

  // Overflow recovery: drop beats through the end of the oversized sequence
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      discard   <= 1'b0;
      len_error <= 1'b0;
    end else if (overflow) begin
      discard   <= 1'b1;
      len_error <= 1'b1;
    end else if (discard && accept && in_last) begin
      discard   <= 1'b0;
    end
  end

  // Emitter state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seq_go     <= 1'b0;
      seq_finish <= 1'b0;
      seq_data   <= '0;
    end else begin
      state      <= state_nxt;
      seq_go     <= go_nxt;
      seq_finish <= finish_nxt;
      seq_data   <= data_nxt;
    end
  end

  // Launch is held off while finish is showing so an all-zero cycle follows it
  always_comb begin
    state_nxt  = state;
    go_nxt     = 1'b0;
    finish_nxt = 1'b0;
    data_nxt   = '0;
    pop        = 1'b0;
    launch     = 1'b0;
    unique case (state)
      IDLE: begin
        if ((pend != '0) && !seq_finish) begin
          launch    = 1'b1;
          pop       = 1'b1;
          go_nxt    = 1'b1;
          data_nxt  = head_data;
          state_nxt = head_last ? REPEAT : STREAM;
        end
      end
      STREAM: begin
        pop        = 1'b1;
        data_nxt   = head_data;
        finish_nxt = head_last;
        if (head_last) state_nxt = IDLE;
      end
      REPEAT: begin
        finish_nxt = 1'b1;
        data_nxt   = seq_data;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_range_sequencer.sv
// Bench for range_sequencer: directed and random sequences checked every cycle against
// a schedule-based model of the emitted bursts, FIFO occupancy and overflow recovery.
module tb_range_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] seq_data;
  logic             seq_go;
  logic             seq_finish;
  logic             busy;
  logic             len_error;

  always #5 clock = ~clock;

  range_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .seq_data(seq_data), .seq_go(seq_go),
    .seq_finish(seq_finish), .busy(busy), .len_error(len_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: FIFO fill level, pending sequences, and a per-cycle output schedule
  int               occ, pend_m, free_at;
  bit               disc_m, lerr_m;
  logic [WIDTH-1:0] cur[$];
  logic [WIDTH+2:0] exp_out[int];
  bit               pops[int];
  bit               launches[int];
  logic [WIDTH+4:0] log_out[int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    occ = 0; pend_m = 0; free_at = 0; disc_m = 0; lerr_m = 0;
    cur.delete(); exp_out.delete(); pops.delete(); launches.delete();
  endtask

  // Completed sequence in cur: burst starts two cycles after completion or after the
  // previous burst plus one idle cycle; a single sample shows twice (go, then finish).
  task automatic schedule();
    int n, start, last_c;
    n = cur.size();
    start = (cyc + 2 > free_at) ? cyc + 2 : free_at;
    launches[start-1] = 1'b1;
    if (n == 1) begin
      exp_out[start]   = {1'b1, 1'b1, 1'b0, cur[0]};
      exp_out[start+1] = {1'b0, 1'b0, 1'b1, cur[0]};
      pops[start-1] = 1'b1;
      last_c = start + 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_out[start+k] = {(k < n-1) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0,
                            (k == n-1) ? 1'b1 : 1'b0, cur[k]};
        pops[start-1+k] = 1'b1;
      end
      last_c = start + n - 1;
    end
    free_at = last_c + 2;
  endtask

  // One cycle: compare DUT against the model, drive inputs, advance the model
  task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic l, output bit acc);
    logic [WIDTH+2:0] want;
    logic [WIDTH+4:0] got;
    bit rdy, ovf, pushed, pop_n, launch_n;
    @(negedge clock);
    got = {len_error, in_ready, busy, seq_go, seq_finish, seq_data};
    log_out[cyc] = got;
    want = exp_out.exists(cyc) ? exp_out[cyc] : '0;
    rdy = (occ < DEPTH) || disc_m;
    check("outputs{busy,go,fin,data}", 32'(got[WIDTH+2:0]), 32'(want));
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("len_error", 32'(len_error), 32'(lerr_m));
    in_valid = v; in_data = d; in_last = l;
    acc = v && rdy;
    ovf = (occ == DEPTH) && (pend_m == 0) && !disc_m;
    pop_n = pops.exists(cyc) ? 1'b1 : 1'b0;
    launch_n = launches.exists(cyc) ? 1'b1 : 1'b0;
    pushed = 1'b0;
    if (acc) begin
      if (disc_m) begin
        if (l) disc_m = 1'b0;
      end else begin
        pushed = 1'b1;
        cur.push_back(d);
        if (l) begin
          schedule();
          cur.delete();
          pend_m++;
        end
      end
    end
    occ = occ + int'(pushed) - int'(pop_n);
    if (launch_n) pend_m--;
    if (ovf) begin
      occ = 0; disc_m = 1'b1; lerr_m = 1'b1; cur.delete();
    end
    cyc++;
  endtask

  task automatic push_beat(input logic [WIDTH-1:0] d, input logic l);
    bit acc;
    int tries = 0;
    do begin
      tick(1'b1, d, l, acc);
      tries++;
    end while (!acc && tries < 200);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: beat 0x%0h not accepted within %0d cycles", d, tries);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'($urandom), acc);
  endtask

  task automatic lit(input string name, input int c, input logic b, input logic g,
                     input logic f, input logic [WIDTH-1:0] d);
    logic [WIDTH+4:0] w;
    w = log_out[c];
    check(name, 32'(w[WIDTH+2:0]), 32'({b, g, f, d}));
  endtask

  int c0, c1, c2, c3, c4, c5;
  logic [WIDTH+4:0] w;

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("reset_go", 32'(seq_go), 32'(0));
    check("reset_finish", 32'(seq_finish), 32'(0));
    check("reset_data", 32'(seq_data), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_len_error", 32'(len_error), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // 5,9,2: go 5 two cycles after last accepted, finish on 2
    c0 = cyc;
    push_beat(8'd5, 1'b0); push_beat(8'd9, 1'b0); push_beat(8'd2, 1'b1);
    idle(8);
    lit("lit_burst_go5", c0+4, 1'b1, 1'b1, 1'b0, 8'd5);
    lit("lit_burst_9", c0+5, 1'b1, 1'b0, 1'b0, 8'd9);
    lit("lit_burst_fin2", c0+6, 1'b0, 1'b0, 1'b1, 8'd2);
    lit("lit_burst_idle", c0+7, 1'b0, 1'b0, 1'b0, 8'd0);

    // single sample 42
    c1 = cyc;
    push_beat(8'd42, 1'b1);
    idle(6);
    lit("lit_single_go", c1+2, 1'b1, 1'b1, 1'b0, 8'd42);
    lit("lit_single_fin", c1+3, 1'b0, 1'b0, 1'b1, 8'd42);
    lit("lit_single_idle", c1+4, 1'b0, 1'b0, 1'b0, 8'd0);

    // back-to-back sequences separated by exactly one idle cycle
    c2 = cyc;
    push_beat(8'd3, 1'b0); push_beat(8'd7, 1'b1); push_beat(8'd10, 1'b0); push_beat(8'd1, 1'b1);
    idle(10);
    lit("lit_b2b_go3", c2+3, 1'b1, 1'b1, 1'b0, 8'd3);
    lit("lit_b2b_fin7", c2+4, 1'b0, 1'b0, 1'b1, 8'd7);
    lit("lit_b2b_gap", c2+5, 1'b0, 1'b0, 1'b0, 8'd0);
    lit("lit_b2b_go10", c2+6, 1'b1, 1'b1, 1'b0, 8'd10);
    lit("lit_b2b_fin1", c2+7, 1'b0, 1'b0, 1'b1, 8'd1);

    // overflow: 17 beats without last, dropped tail, then 4,8
    c3 = cyc;
    for (int i = 0; i < 17; i++) push_beat(8'(100 + i), 1'b0);
    push_beat(8'd55, 1'b1);
    push_beat(8'd4, 1'b0); push_beat(8'd8, 1'b1);
    idle(8);
    w = log_out[c3+16];
    check("lit_ovf_ready_low", 32'(w[WIDTH+3]), 32'(0));
    check("lit_ovf_no_err_yet", 32'(w[WIDTH+4]), 32'(0));
    w = log_out[c3+17];
    check("lit_ovf_discard_ready", 32'(w[WIDTH+3]), 32'(1));
    check("lit_ovf_err_set", 32'(w[WIDTH+4]), 32'(1));
    lit("lit_ovf_go4", c3+22, 1'b1, 1'b1, 1'b0, 8'd4);
    lit("lit_ovf_fin8", c3+23, 1'b0, 1'b0, 1'b1, 8'd8);

    // input gaps do not create output gaps
    c4 = cyc;
    push_beat(8'd1, 1'b0); idle(2); push_beat(8'd6, 1'b0); idle(1); push_beat(8'd4, 1'b1);
    idle(6);
    lit("lit_gap_go1", c4+7, 1'b1, 1'b1, 1'b0, 8'd1);
    lit("lit_gap_6", c4+8, 1'b1, 1'b0, 1'b0, 8'd6);
    lit("lit_gap_fin4", c4+9, 1'b0, 1'b0, 1'b1, 8'd4);

    // random sequences, including occasional oversized ones
    for (int s = 0; s < 60; s++) begin
      int r, n;
      r = $urandom_range(0, 99);
      if (r < 80)      n = $urandom_range(1, 6);
      else if (r < 90) n = $urandom_range(13, 16);
      else             n = $urandom_range(17, 20);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        push_beat(8'($urandom), (k == n-1) ? 1'b1 : 1'b0);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(40);

    // reset in the middle of a burst
    c5 = cyc;
    for (int i = 1; i <= 5; i++) push_beat(8'(i), (i == 5) ? 1'b1 : 1'b0);
    idle(3);
    @(posedge clock);
    #1;
    check("mid_stream_busy", 32'(busy), 32'(1));
    check("mid_stream_data", 32'(seq_data), 32'(3));
    #1;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("rst_mid_go", 32'(seq_go), 32'(0));
    check("rst_mid_finish", 32'(seq_finish), 32'(0));
    check("rst_mid_data", 32'(seq_data), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_len_error", 32'(len_error), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(12);
    push_beat(8'd77, 1'b0); push_beat(8'd11, 1'b1);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the bench always ends
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
